// File: rtl/rv_mc_control.sv
`default_nettype none
// ============================================================================
// Module      : rv_mc_control
// Description : Multi-cycle RV32I control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP)
//               with memory-timeout watchdog and illegal-opcode trap.
// Revision    : 1.0 - initial release
// ============================================================================
module rv_mc_control #(
    parameter int OPCODE_W    = 7,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                branch_taken,
    input  logic                mem_ready,
    input  logic                trap_ack,
    output logic                pc_write,
    output logic                pc_sel,
    output logic                ir_write,
    output logic                reg_write,
    output logic                mem_req,
    output logic                mem_we,
    output logic                mem_is_instr,
    output logic                alu_src_b,
    output logic [1:0]          wb_sel,
    output logic                trap,
    output logic [1:0]          trap_cause,
    output logic [2:0]          state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [OPCODE_W-1:0] c_OP_R      = OPCODE_W'(7'b0110011);
    localparam logic [OPCODE_W-1:0] c_OP_IALU   = OPCODE_W'(7'b0010011);
    localparam logic [OPCODE_W-1:0] c_OP_LOAD   = OPCODE_W'(7'b0000011);
    localparam logic [OPCODE_W-1:0] c_OP_STORE  = OPCODE_W'(7'b0100011);
    localparam logic [OPCODE_W-1:0] c_OP_BRANCH = OPCODE_W'(7'b1100011);
    localparam logic [OPCODE_W-1:0] c_OP_JAL    = OPCODE_W'(7'b1101111);
    localparam logic [OPCODE_W-1:0] c_OP_LUI    = OPCODE_W'(7'b0110111);

    localparam logic [1:0] c_CAUSE_NONE    = 2'b00;
    localparam logic [1:0] c_CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] c_CAUSE_TIMEOUT = 2'b10;

    localparam logic [CNT_W-1:0] c_CNT_LIMIT = CNT_W'(MEM_TIMEOUT - 1);

    state_t              r_state;
    state_t              w_next;
    logic [OPCODE_W-1:0] r_op;
    logic [CNT_W-1:0]    r_cnt;
    logic [1:0]          r_cause;
    logic [1:0]          w_cause_next;
    logic                w_legal;
    logic                w_limit;
    logic                w_mem_wait;

    always_comb begin
        w_legal = 1'b0;
        case (opcode)
            c_OP_R, c_OP_IALU, c_OP_LOAD, c_OP_STORE,
            c_OP_BRANCH, c_OP_JAL, c_OP_LUI: w_legal = 1'b1;
            default:                         w_legal = 1'b0;
        endcase
    end

    assign w_limit    = (r_cnt == c_CNT_LIMIT);
    assign w_mem_wait = ((r_state == S_FETCH) || (r_state == S_MEM)) && !mem_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_op    <= '0;
            r_cnt   <= '0;
            r_cause <= c_CAUSE_NONE;
        end else begin
            r_state <= w_next;
            r_cause <= w_cause_next;
            if (r_state == S_DECODE) begin
                r_op <= opcode;
            end
            // Every state change starts a fresh wait window.
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if (w_mem_wait) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_next       = r_state;
        w_cause_next = r_cause;
        pc_write     = 1'b0;
        pc_sel       = 1'b0;
        ir_write     = 1'b0;
        reg_write    = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_is_instr = 1'b0;
        alu_src_b    = 1'b0;
        wb_sel       = 2'b00;
        trap         = 1'b0;
        trap_cause   = c_CAUSE_NONE;
        state        = r_state;

        case (r_state)
            S_FETCH: begin
                mem_req      = 1'b1;
                mem_is_instr = 1'b1;
                // A ready response on the limit cycle still counts as success.
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    w_next   = S_DECODE;
                end else if (w_limit) begin
                    w_next       = S_TRAP;
                    w_cause_next = c_CAUSE_TIMEOUT;
                end
            end
            S_DECODE: begin
                if (w_legal) begin
                    w_next = S_EXEC;
                end else begin
                    w_next       = S_TRAP;
                    w_cause_next = c_CAUSE_ILLEGAL;
                end
            end
            S_EXEC: begin
                alu_src_b = (r_op == c_OP_R);
                case (r_op)
                    c_OP_BRANCH: begin
                        pc_write = branch_taken;
                        pc_sel   = 1'b1;
                        w_next   = S_FETCH;
                    end
                    c_OP_JAL: begin
                        pc_write = 1'b1;
                        pc_sel   = 1'b1;
                        w_next   = S_WB;
                    end
                    c_OP_LOAD, c_OP_STORE: w_next = S_MEM;
                    default:               w_next = S_WB;
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = (r_op == c_OP_STORE);
                if (mem_ready) begin
                    w_next = (r_op == c_OP_STORE) ? S_FETCH : S_WB;
                end else if (w_limit) begin
                    w_next       = S_TRAP;
                    w_cause_next = c_CAUSE_TIMEOUT;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                if (r_op == c_OP_LOAD) begin
                    wb_sel = 2'b01;
                end else if (r_op == c_OP_JAL) begin
                    wb_sel = 2'b10;
                end
                w_next = S_FETCH;
            end
            S_TRAP: begin
                trap       = 1'b1;
                trap_cause = r_cause;
                if (trap_ack) begin
                    w_next       = S_FETCH;
                    w_cause_next = c_CAUSE_NONE;
                end
            end
            default: begin
                state        = 3'd0;
                w_next       = S_FETCH;
                w_cause_next = c_CAUSE_NONE;
            end
        endcase

        // Outputs are quiet while reset is held, even before the register clears.
        if (rst) begin
            pc_write     = 1'b0;
            pc_sel       = 1'b0;
            ir_write     = 1'b0;
            reg_write    = 1'b0;
            mem_req      = 1'b0;
            mem_we       = 1'b0;
            mem_is_instr = 1'b0;
            alu_src_b    = 1'b0;
            wb_sel       = 2'b00;
            trap         = 1'b0;
            trap_cause   = c_CAUSE_NONE;
            state        = 3'd0;
        end
    end

endmodule
`default_nettype wire

// File: doc/rv_mc_control.md
Name: rv_mc_control

Overview:
- Multi-cycle RV32I control unit; the sequential successor to the single-cycle opcode decoder.
- An FSM steps each instruction through FETCH/DECODE/EXEC/MEM/WB. It drives datapath enables and mux selects, and runs a req/ready handshake with the shared instruction/data memory.
- Adds a memory-timeout watchdog and an illegal-opcode trap with external acknowledge.
- Sits between the instruction register (opcode source) and the datapath, register file and memory port.

Parameters:
- OPCODE_W, 7, opcode field width.
- MEM_TIMEOUT, 16, max cycles mem_req may stay unanswered before trapping (range 2..255).
- CNT_W, 8, timeout counter width; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- opcode  in  OPCODE_W  instr[6:0] from instruction register
- branch_taken  in  1  ALU compare result, valid in EXEC
- mem_ready  in  1  memory completes current request this cycle
- trap_ack  in  1  handler accepted the trap
- pc_write  out  1  PC load enable
- pc_sel  out  1  0=PC+4, 1=ALU target
- ir_write  out  1  instruction register load
- reg_write  out  1  register file write enable
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  1=store
- mem_is_instr  out  1  1=address from PC, 0=from ALU
- alu_src_b  out  1  1=register rs2, 0=immediate
- wb_sel  out  2  00=ALU, 01=memory data, 10=PC+4
- trap  out  1  trap pending
- trap_cause  out  2  01=illegal opcode, 10=memory timeout, 00=none
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5

Behaviour:
- Reset:
  - state to FETCH; timeout counter 0; trap_cause 00.
  - While rst is high, every output is 0 (state reads 0).
  - First mem_req appears in the first cycle with rst low.
- Outputs are Moore: decoded from the registered state plus the opcode latched in DECODE (op_q). Exceptions: pc_write in EXEC uses the live branch_taken; pc_write/ir_write in FETCH are gated by the live mem_ready.
- FETCH:
  - mem_req=1, mem_is_instr=1, mem_we=0.
  - On mem_ready: ir_write=1, pc_write=1, pc_sel=0; next state DECODE.
- DECODE:
  - 1 cycle; latches opcode into op_q.
  - Legal opcodes: 0110011 R, 0010011 I-ALU, 0000011 LOAD, 0100011 STORE, 1100011 BRANCH, 1101111 JAL, 0110111 LUI → EXEC.
  - Any other opcode → TRAP, cause 01.
- EXEC (1 cycle), by op_q:
  - R: alu_src_b=1.
  - Every other class: alu_src_b=0.
  - BRANCH: pc_write=branch_taken, pc_sel=1.
  - JAL: pc_write=1, pc_sel=1.
- EXEC next state:
  - R, I-ALU, LUI, JAL → WB.
  - LOAD, STORE → MEM.
  - BRANCH → FETCH.
- MEM:
  - mem_req=1, mem_is_instr=0, mem_we=1 for STORE.
  - On mem_ready: LOAD → WB, STORE → FETCH.
- WB:
  - reg_write=1, 1 cycle, then FETCH.
  - wb_sel=01 for LOAD, 10 for JAL, 00 otherwise.
- Minimum latency with zero-wait memory:
  - R/I-ALU/LUI/JAL: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH: 3 cycles.
  - Each memory wait cycle adds 1.
- Timeout counter:
  - Counts in FETCH/MEM each cycle mem_ready=0; clears on every state change.
  - When the counter reaches MEM_TIMEOUT-1 and mem_ready=0 → TRAP, cause 10.
  - mem_ready in the same cycle as the limit wins: normal transition, no trap.
  - No pc_write, reg_write or ir_write is issued on a timed-out access.
- TRAP:
  - trap=1 and trap_cause held; all enables 0; mem_req=0.
  - On trap_ack → FETCH, trap_cause cleared to 00.
  - trap_ack outside TRAP is ignored.
- Reset mid-operation, in any state including mid-handshake or TRAP: the next cycle is FETCH, the counter clears and any pending trap is dropped.
- Unreachable state encodings (6, 7) → FETCH on the next cycle, all outputs 0.

Test Plan:
- Reset, then R-type 0110011 with mem_ready always 1 → states 0,1,2,4,0:
  - ir_write and pc_write in cycle 1; alu_src_b=1 in EXEC; reg_write=1 with wb_sel=00 in cycle 4.
- LOAD 0000011 with mem_ready delayed 3 cycles in MEM → MEM held 4 cycles with mem_req=1 and mem_we=0; then WB with wb_sel=01; 8 cycles total.
- STORE 0100011 → MEM with mem_we=1, mem_is_instr=0; reg_write stays 0 throughout; returns to FETCH.
- BRANCH 1100011, branch_taken=1 → pc_write=1, pc_sel=1 in EXEC. Repeat with branch_taken=0 → pc_write=0; FETCH follows in both cases.
- Opcode 1111111 → TRAP with trap=1, cause=01; hold 5 cycles without trap_ack, trap stays set; trap_ack → FETCH, cause 00.
- MEM_TIMEOUT=16, mem_ready held 0 in FETCH → TRAP cause 10 after exactly 16 FETCH cycles. Repeat with mem_ready=1 on the 16th cycle → DECODE, no trap. Assert rst mid-wait → FETCH with counter 0.
